bcd_scan_decoder: RTL and testbench
===================================

BCD_SCAN_DECODER -- requirements
Module: bcd_scan_decoder

Interface
REQ-001 Parameter DIGITS, default 4: number of packed BCD digits per word, range 1..8.
REQ-002 Parameter DWELL, default 8: cycles each digit is held on the outputs, range 1..255.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  in_bcd holds a word to display.
REQ-006 in_ready  out  1  block can accept a word.
REQ-007 in_bcd  in  4*DIGITS  packed BCD word; digit i at bits [4i+3:4i], digit 0 least significant.
REQ-008 y  out  10  one-hot decimal of the current digit; y[k]=1 for code k.
REQ-009 dig_sel  out  DIGITS  one-hot index of the current digit.
REQ-010 busy  out  1  scan in progress.
REQ-011 err  out  1  current digit code is 10..15.
REQ-012 done  out  1  one-cycle pulse at the end of a scan.

Function
REQ-013 FSM states: IDLE, SCAN, DONE.
REQ-014 IDLE: in_ready=1, busy=0, y=0, dig_sel=0, err=0.
REQ-015 in_valid&&in_ready at an edge captures in_bcd into an internal register, sets digit index to 0 and dwell counter to 0, and moves to SCAN.
REQ-016 Latency: y, dig_sel and err reflect digit 0 in the first cycle after the capture edge.
REQ-017 SCAN: in_ready=0, busy=1, dig_sel=1<<idx, y and err decoded from the captured digit idx; in_bcd and in_valid are ignored.
REQ-018 Dwell counter increments each SCAN cycle; at DWELL-1 it wraps to 0 and idx increments.
REQ-019 When idx=DIGITS-1 and the counter is at DWELL-1, the next state is DONE.
REQ-020 DONE lasts one cycle: done=1, busy=0, in_ready=0, y=0, dig_sel=0; the next state is IDLE.
REQ-021 Codes 10..15 give y=0 and err=1 for that digit's dwell; the scan continues.
REQ-022 DWELL=1 gives a new digit every cycle; a scan lasts DIGITS+1 cycles from capture to the DONE cycle inclusive.
REQ-023 Back-to-back: a new capture is possible no earlier than the first IDLE cycle after DONE.

Reset
REQ-024 rst=1 at an edge forces IDLE, clears idx, the counter and the captured word, and drives in_ready=1 in the following cycle.
REQ-025 rst overrides a simultaneous in_valid; no capture occurs.
REQ-026 rst during SCAN aborts the scan with no done pulse; all outputs return to REQ-014 values the next cycle.

Configuration
REQ-027 Macro BCD_LZB_EN enables leading-zero blanking.
REQ-028 With BCD_LZB_EN: a digit with code 0 above the most significant nonzero digit, and not digit 0, shows y=0 and err=0 while dig_sel stays active and timing is unchanged.
REQ-029 Without BCD_LZB_EN: every digit is decoded per REQ-017 and REQ-021.

Structure
REQ-030 Package bcd_pkg holds the FSM state typedef, BCD_MAX=9 and the code-to-one-hot constant table.
REQ-031 Sub-module bcd_onehot_dec: combinational, 4-bit code in, 10-bit one-hot plus an invalid flag out; instantiated once in the top module.

Verification
REQ-032 Bench uses DIGITS=4, DWELL=2.
REQ-033 Capture 16'h1234: digits shown in order 4,3,2,1 with y=10'h010, 10'h008, 10'h004, 10'h002, each for 2 cycles, dig_sel=1,2,4,8; done pulses on cycle 9 after capture.
REQ-034 Capture 16'h00A5: err=0 for digit 0 (y=10'h020); err=1 and y=0 for digit 1.
REQ-035 Capture 16'h0070 with BCD_LZB_EN: digit 0 y=10'h001, digit 1 y=10'h080, digits 2 and 3 y=0; without the macro, digits 2 and 3 show y=10'h001.
REQ-036 Assert rst in the third SCAN cycle of 16'h9999: outputs return to IDLE values the next cycle, no done pulse, in_ready=1.
REQ-037 Hold in_valid high with 16'h5678 throughout a scan of 16'h1111: in_bcd is ignored until IDLE, and 16'h5678 is captured on the first IDLE edge.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD scan decoder.
// Holds the FSM state encoding, the largest legal BCD code and the code-to-one-hot table.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Entry k is the one-hot pattern for code k; codes 10..15 map to all zeros.
  localparam logic [15:0][9:0] ONEHOT_TBL = {
    10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000,
    10'h200, 10'h100, 10'h080, 10'h040, 10'h020,
    10'h010, 10'h008, 10'h004, 10'h002, 10'h001
  };

endpackage

// File: rtl/bcd_onehot_dec.sv
// Combinational decoder: 4-bit BCD code to 10-bit one-hot, with a flag for codes 10..15.
module bcd_onehot_dec
  import bcd_pkg::*;
(
  input  logic [3:0] code,
  output logic [9:0] onehot,
  output logic       invalid
);

  assign onehot  = ONEHOT_TBL[code];
  assign invalid = (code > BCD_MAX);

endmodule

// File: rtl/bcd_scan_decoder.sv
// Captures a packed BCD word and scans its digits one at a time, each held for DWELL cycles.
// Define BCD_LZB_EN to blank leading zero digits (digit 0 is never blanked).
module bcd_scan_decoder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DWELL  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic [9:0]            y,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  busy,
  output logic                  err,
  output logic                  done
);

  localparam int              IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [7:0]      LAST_CNT = 8'(DWELL - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [4*DIGITS-1:0]  word_q, word_d;

  logic [3:0]           cur_code;
  logic [9:0]           dec_y;
  logic                 dec_inv;
  logic                 blank;

  assign cur_code = word_q[4*idx_q +: 4];

  bcd_onehot_dec u_dec (
    .code    (cur_code),
    .onehot  (dec_y),
    .invalid (dec_inv)
  );

`ifdef BCD_LZB_EN
  // zero_above[i] is set when digits i..DIGITS-1 are all zero.
  logic [DIGITS:0] zero_above;
  assign zero_above[DIGITS] = 1'b1;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lzb
    assign zero_above[gi] = zero_above[gi+1] && (word_q[4*gi +: 4] == 4'd0);
  end
  assign blank = zero_above[idx_q] && (idx_q != '0);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    y        = '0;
    dig_sel  = '0;
    err      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d  = in_bcd;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        busy    = 1'b1;
        dig_sel = DIGITS'(1) << idx_q;
        if (!blank) begin
          y   = dec_y;
          err = dec_inv;
        end
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_bcd_scan_decoder.sv
// Scoreboard bench for bcd_scan_decoder with DIGITS=4, DWELL=2.
// Expected per-cycle outputs are queued when a word is driven and compared as the DUT produces them.
module tb_bcd_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic [9:0]  y;
  logic [3:0]  dig_sel;
  logic        busy;
  logic        err;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  // Packed observation: {in_ready, busy, done, err, dig_sel[3:0], y[9:0]}
  logic [17:0] exp_q[$];

  localparam logic [17:0] OBS_IDLE = {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 10'h000};
  localparam logic [17:0] OBS_DONE = {1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 10'h000};

  always #5 clk = ~clk;

  bcd_scan_decoder #(.DIGITS(4), .DWELL(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bcd   (in_bcd),
    .y        (y),
    .dig_sel  (dig_sel),
    .busy     (busy),
    .err      (err),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got rdy/busy/done/err=%b%b%b%b sel=%h y=%h  exp %b%b%b%b sel=%h y=%h",
               tag, got[17], got[16], got[15], got[14], got[13:10], got[9:0],
               want[17], want[16], want[15], want[14], want[13:10], want[9:0]);
    end else begin
      $display("ok   %s sel=%h y=%h err=%b done=%b", tag, got[13:10], got[9:0], got[14], got[15]);
    end
  endtask

  function automatic logic [17:0] sample();
    return {in_ready, busy, done, err, dig_sel, y};
  endfunction

  function automatic logic [17:0] exp_digit(input logic [15:0] w, input int i);
    logic [3:0] c;
    logic [9:0] yy;
    logic       e;
    c  = w[4*i +: 4];
    yy = (c <= 4'd9) ? (10'b1 << c) : 10'b0;
    e  = (c > 4'd9);
`ifdef BCD_LZB_EN
    begin
      logic [15:0] above;
      above = w >> (4*i);
      if (i != 0 && above == 16'h0) begin
        yy = '0;
        e  = 1'b0;
      end
    end
`endif
    return {1'b0, 1'b1, 1'b0, e, 4'(1 << i), yy};
  endfunction

  task automatic push_scan(input logic [15:0] w);
    for (int i = 0; i < 4; i++)
      for (int d = 0; d < 2; d++)
        exp_q.push_back(exp_digit(w, i));
    exp_q.push_back(OBS_DONE);
    exp_q.push_back(OBS_IDLE);
  endtask

  // Entered just after a capture edge; pops one expectation per cycle.
  task automatic drain(input string name, input int drop_valid_at, input int rst_at);
    int k = 0;
    logic [17:0] e;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("%s_c%0d", name, k + 1), sample(), e);
      if (k == rst_at) rst = 1'b1;
      @(posedge clk); #1;
      if (k == rst_at) rst = 1'b0;
      if (k == drop_valid_at) in_valid = 1'b0;
      k++;
    end
  endtask

  // Waits (bounded) for in_ready, then presents w across one capture edge.
  task automatic send(input logic [15:0] w, input logic hold);
    int n = 0;
    in_bcd   = w;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_before_capture", {17'h0, in_ready}, 18'h1);
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    in_bcd   = 16'h4321;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_hold_with_valid", sample(), OBS_IDLE);
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("after_reset_release", sample(), OBS_IDLE);
    @(posedge clk); #1;

    send(16'h1234, 1'b0);
    push_scan(16'h1234);
    drain("w1234", -1, -1);

    send(16'h00A5, 1'b0);
    push_scan(16'h00A5);
    drain("w00A5", -1, -1);

    send(16'h0070, 1'b0);
    push_scan(16'h0070);
    drain("w0070", -1, -1);

    // Abort in the third SCAN cycle: digit 1 is already showing.
    send(16'h9999, 1'b0);
    exp_q.push_back(exp_digit(16'h9999, 0));
    exp_q.push_back(exp_digit(16'h9999, 0));
    exp_q.push_back(exp_digit(16'h9999, 1));
    repeat (4) exp_q.push_back(OBS_IDLE);
    drain("rst9999", -1, 2);

    // in_valid stays high with a different word during the scan.
    send(16'h1111, 1'b1);
    in_bcd = 16'h5678;
    push_scan(16'h1111);
    push_scan(16'h5678);
    drain("hold", 9, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
